// File: rtl/mem_request_responder.sv
// ---------------------------------------------------------------------------
// mem_request_responder
//
// Backing store and fixed-latency model placed behind the memory controller
// request ports in simulation. One write and one read request may be accepted
// per cycle with no backpressure. Writes commit to storage at the accepting
// edge. Each accepted request is acknowledged after a fixed pipeline latency,
// strictly in acceptance order per port.
//
// Ports
//   clk             clock, all logic on posedge
//   reset           synchronous, active-high reset
//   wr_address      write request address
//   wr_en           write request valid
//   wr_data         write request data
//   wr_ret_address  address of the write being acknowledged
//   wr_ret_ack      one-cycle pulse per accepted write, WR_LATENCY after accept
//   rd_address      read request address
//   rd_en           read request valid
//   rd_ret_data     read return data
//   rd_ret_address  address of the read being returned
//   rd_ret_ack      one-cycle pulse per accepted read, RD_LATENCY after accept
//   rd_inflight     number of accepted reads not yet returned
// ---------------------------------------------------------------------------
module mem_request_responder #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 16,
    parameter int MEM_BITS   = 8,
    parameter int RD_LATENCY = 4,
    parameter int WR_LATENCY = 2
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [ADDR_WIDTH-1:0]           wr_address,
    input  logic                            wr_en,
    input  logic [DATA_WIDTH-1:0]           wr_data,
    output logic [ADDR_WIDTH-1:0]           wr_ret_address,
    output logic                            wr_ret_ack,
    input  logic [ADDR_WIDTH-1:0]           rd_address,
    input  logic                            rd_en,
    output logic [DATA_WIDTH-1:0]           rd_ret_data,
    output logic [ADDR_WIDTH-1:0]           rd_ret_address,
    output logic                            rd_ret_ack,
    output logic [$clog2(RD_LATENCY+1)-1:0] rd_inflight
);

    localparam int DEPTH = 2 ** MEM_BITS;
    localparam int CNT_W = $clog2(RD_LATENCY + 1);

    // -----------------------------------------------------------------------
    // Storage and request qualification
    // -----------------------------------------------------------------------
    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic                wr_accept;
    logic                rd_accept;
    logic [MEM_BITS-1:0] wr_idx;
    logic [MEM_BITS-1:0] rd_idx;

    // Requests seen while reset is high are dropped entirely.
    assign wr_accept = wr_en & ~reset;
    assign rd_accept = rd_en & ~reset;

    // Only the low MEM_BITS address bits select a word; the full address is
    // still carried down the pipelines and echoed on the return.
    assign wr_idx = wr_address[MEM_BITS-1:0];
    assign rd_idx = rd_address[MEM_BITS-1:0];

    // NOTE: storage has no reset branch; contents survive reset and a
    // reset-free array maps onto plain RAM instead of a wide flop bank.
    always_ff @(posedge clk) begin
        if (wr_accept) begin
            mem[wr_idx] <= wr_data;
        end
    end

    // -----------------------------------------------------------------------
    // Write return pipeline: stage 0 loads at the accepting edge, so the last
    // stage (WR_LATENCY-1) is visible exactly WR_LATENCY cycles after accept.
    // -----------------------------------------------------------------------
    logic [WR_LATENCY-1:0] wr_vld;
    logic [ADDR_WIDTH-1:0] wr_addr_pipe [WR_LATENCY];

    // NOTE: every sequential block uses non-blocking assignments so each
    // stage samples its neighbour's pre-edge value, giving a true shift.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_vld <= '0;
            for (int i = 0; i < WR_LATENCY; i++) begin
                wr_addr_pipe[i] <= '0;
            end
        end else begin
            wr_vld[0] <= wr_en;
            if (wr_en) begin
                wr_addr_pipe[0] <= wr_address;
            end
            for (int i = 1; i < WR_LATENCY; i++) begin
                wr_vld[i] <= wr_vld[i-1];
                // Payload only advances with a valid entry, so the output
                // stage holds the last returned address between acks.
                if (wr_vld[i-1]) begin
                    wr_addr_pipe[i] <= wr_addr_pipe[i-1];
                end
            end
        end
    end

    assign wr_ret_ack     = wr_vld[WR_LATENCY-1];
    assign wr_ret_address = wr_addr_pipe[WR_LATENCY-1];

    // -----------------------------------------------------------------------
    // Read return pipeline. Storage is sampled into stage 0 at the accepting
    // edge; because the write above lands on the same edge, a same-index
    // collision returns the pre-write word (read-first).
    // -----------------------------------------------------------------------
    logic [RD_LATENCY-1:0] rd_vld;
    logic [ADDR_WIDTH-1:0] rd_addr_pipe [RD_LATENCY];
    logic [DATA_WIDTH-1:0] rd_data_pipe [RD_LATENCY];

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_vld <= '0;
            for (int i = 0; i < RD_LATENCY; i++) begin
                rd_addr_pipe[i] <= '0;
                rd_data_pipe[i] <= '0;
            end
        end else begin
            rd_vld[0] <= rd_en;
            if (rd_en) begin
                rd_addr_pipe[0] <= rd_address;
                rd_data_pipe[0] <= mem[rd_idx];
            end
            for (int i = 1; i < RD_LATENCY; i++) begin
                rd_vld[i] <= rd_vld[i-1];
                if (rd_vld[i-1]) begin
                    rd_addr_pipe[i] <= rd_addr_pipe[i-1];
                    rd_data_pipe[i] <= rd_data_pipe[i-1];
                end
            end
        end
    end

    assign rd_ret_ack     = rd_vld[RD_LATENCY-1];
    assign rd_ret_address = rd_addr_pipe[RD_LATENCY-1];
    assign rd_ret_data    = rd_data_pipe[RD_LATENCY-1];

    // -----------------------------------------------------------------------
    // Outstanding read counter. It retires on the edge that consumes the
    // output stage, so with continuous reads it saturates at RD_LATENCY.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_inflight <= '0;
        end else begin
            unique case ({rd_accept, rd_vld[RD_LATENCY-1]})
                2'b10:   rd_inflight <= rd_inflight + CNT_W'(1);
                2'b01:   rd_inflight <= rd_inflight - CNT_W'(1);
                default: rd_inflight <= rd_inflight;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_request_responder.sv
// ---------------------------------------------------------------------------
// tb_mem_request_responder
//
// Directed bench for mem_request_responder with default parameters. The
// stimulus process pushes each expected return (address, data, due cycle)
// into a per-port queue; an independent monitor pops and compares whenever
// the DUT raises an ack, and flags acks that are late, early or unexpected.
// ---------------------------------------------------------------------------
module tb_mem_request_responder;

    localparam int ADDR_WIDTH = 16;
    localparam int DATA_WIDTH = 16;
    localparam int MEM_BITS   = 8;
    localparam int RD_LATENCY = 4;
    localparam int WR_LATENCY = 2;

    typedef struct {
        logic [ADDR_WIDTH-1:0] addr;
        int                    due;
    } wr_item_t;

    typedef struct {
        logic [ADDR_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0] data;
        int                    due;
    } rd_item_t;

    logic                  clk;
    logic                  reset;
    logic [ADDR_WIDTH-1:0] wr_address;
    logic                  wr_en;
    logic [DATA_WIDTH-1:0] wr_data;
    logic [ADDR_WIDTH-1:0] wr_ret_address;
    logic                  wr_ret_ack;
    logic [ADDR_WIDTH-1:0] rd_address;
    logic                  rd_en;
    logic [DATA_WIDTH-1:0] rd_ret_data;
    logic [ADDR_WIDTH-1:0] rd_ret_address;
    logic                  rd_ret_ack;
    logic [2:0]            rd_inflight;

    mem_request_responder #(
        .ADDR_WIDTH(ADDR_WIDTH),
        .DATA_WIDTH(DATA_WIDTH),
        .MEM_BITS  (MEM_BITS),
        .RD_LATENCY(RD_LATENCY),
        .WR_LATENCY(WR_LATENCY)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .wr_address    (wr_address),
        .wr_en         (wr_en),
        .wr_data       (wr_data),
        .wr_ret_address(wr_ret_address),
        .wr_ret_ack    (wr_ret_ack),
        .rd_address    (rd_address),
        .rd_en         (rd_en),
        .rd_ret_data   (rd_ret_data),
        .rd_ret_address(rd_ret_address),
        .rd_ret_ack    (rd_ret_ack),
        .rd_inflight   (rd_inflight)
    );

    int       n_checks = 0;
    int       n_errors = 0;
    int       cyc      = 0;
    bit       mon_on   = 1'b0;
    wr_item_t wr_q[$];
    rd_item_t rd_q[$];
    wr_item_t wm;
    rd_item_t rm;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Number of rising edges so far; read only at negedges where it is stable.
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    // -----------------------------------------------------------------------
    // Monitor: one decision per port per cycle, sampled at the falling edge.
    // -----------------------------------------------------------------------
    always @(negedge clk) begin
        if (mon_on) begin
            if (wr_ret_ack === 1'b1) begin
                if (wr_q.size() == 0) begin
                    check("wr_unexpected_ack", 32'd1, 32'd0);
                end else begin
                    wm = wr_q.pop_front();
                    check("wr_ret_address", 32'(wr_ret_address), 32'(wm.addr));
                    check("wr_ack_cycle", 32'(cyc), 32'(wm.due));
                end
            end else if (wr_q.size() != 0 && wr_q[0].due <= cyc) begin
                wm = wr_q.pop_front();
                check("wr_missing_ack", {31'd0, wr_ret_ack}, 32'd1);
            end

            if (rd_ret_ack === 1'b1) begin
                if (rd_q.size() == 0) begin
                    check("rd_unexpected_ack", 32'd1, 32'd0);
                end else begin
                    rm = rd_q.pop_front();
                    check("rd_ret_address", 32'(rd_ret_address), 32'(rm.addr));
                    check("rd_ret_data", 32'(rd_ret_data), 32'(rm.data));
                    check("rd_ack_cycle", 32'(cyc), 32'(rm.due));
                end
            end else if (rd_q.size() != 0 && rd_q[0].due <= cyc) begin
                rm = rd_q.pop_front();
                check("rd_missing_ack", {31'd0, rd_ret_ack}, 32'd1);
            end
        end
    end

    // -----------------------------------------------------------------------
    // Stimulus helpers. Each call starts at a falling edge, drives the request
    // for the next rising edge, records expectations, and returns one falling
    // edge later. A request driven at cycle k is sampled at edge k+1 and must
    // be visible at the falling edge where cyc == k + LATENCY.
    // -----------------------------------------------------------------------
    task automatic step(input logic we, input logic [15:0] wa, input logic [15:0] wd,
                        input logic re, input logic [15:0] ra, input logic [15:0] rexp);
        wr_en      = we;
        wr_address = wa;
        wr_data    = wd;
        rd_en      = re;
        rd_address = ra;
        if (we && !reset) wr_q.push_back('{addr: wa, due: cyc + WR_LATENCY});
        if (re && !reset) rd_q.push_back('{addr: ra, data: rexp, due: cyc + RD_LATENCY});
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 16'h0, 16'h0, 1'b0, 16'h0, 16'h0);
    endtask

    task automatic wr(input logic [15:0] a, input logic [15:0] d);
        step(1'b1, a, d, 1'b0, 16'h0, 16'h0);
    endtask

    task automatic rd(input logic [15:0] a, input logic [15:0] exp_d);
        step(1'b0, 16'h0, 16'h0, 1'b1, a, exp_d);
    endtask

    int inflight_exp [10] = '{1, 2, 3, 4, 4, 4, 3, 2, 1, 0};

    initial begin
        reset      = 1'b1;
        wr_en      = 1'b0;
        rd_en      = 1'b0;
        wr_address = '0;
        wr_data    = '0;
        rd_address = '0;
        repeat (3) @(negedge clk);

        // Reset state
        check("reset_wr_ret_ack", {31'd0, wr_ret_ack}, 32'd0);
        check("reset_wr_ret_address", 32'(wr_ret_address), 32'd0);
        check("reset_rd_ret_ack", {31'd0, rd_ret_ack}, 32'd0);
        check("reset_rd_ret_address", 32'(rd_ret_address), 32'd0);
        check("reset_rd_ret_data", 32'(rd_ret_data), 32'd0);
        check("reset_rd_inflight", 32'(rd_inflight), 32'd0);
        reset  = 1'b0;
        mon_on = 1'b1;

        // Preload every word with 0xA500+index.
        for (int i = 0; i < 256; i++) wr(16'(i), 16'hA500 + 16'(i));
        idle(2);

        // Streaming pass 1: same-cycle write/read of address n, read-first.
        for (int n = 0; n < 128; n++) step(1'b1, 16'(n), 16'(n), 1'b1, 16'(n), 16'hA500 + 16'(n));
        // Streaming pass 2: the new data n is returned.
        for (int n = 0; n < 128; n++) rd(16'(n), 16'(n));
        idle(6);

        // Write then read one cycle later.
        wr(16'h0005, 16'hBEEF);
        rd(16'h0005, 16'hBEEF);
        idle(6);

        // Same-cycle collision, then a later read sees the new value.
        wr(16'h0010, 16'h1111);
        step(1'b1, 16'h0010, 16'h2222, 1'b1, 16'h0010, 16'h1111);
        rd(16'h0010, 16'h2222);
        idle(6);

        // Aliasing: 0x0103 and 0x0003 share index 0x03.
        wr(16'h0103, 16'hAAAA);
        rd(16'h0003, 16'hAAAA);
        idle(6);

        // rd_inflight ramp with six back-to-back reads (data equals address).
        for (int i = 0; i < 10; i++) begin
            if (i < 6) rd(16'h0020 + 16'(i), 16'h0020 + 16'(i));
            else idle(1);
            check($sformatf("rd_inflight_%0d", i), 32'(rd_inflight), 32'(inflight_exp[i]));
        end
        idle(4);

        // Reset mid-flight: committed write survives, in-flight reads vanish,
        // and requests presented during reset are ignored.
        wr(16'h0040, 16'h5A5A);
        idle(4);
        rd(16'h0041, 16'h0041);
        rd(16'h0042, 16'h0042);
        rd(16'h0043, 16'h0043);
        reset = 1'b1;
        wr_q.delete();
        rd_q.delete();
        step(1'b1, 16'h0040, 16'hDEAD, 1'b1, 16'h0044, 16'h0000);
        reset = 1'b0;
        check("midreset_rd_inflight", 32'(rd_inflight), 32'd0);
        check("midreset_rd_ret_ack", {31'd0, rd_ret_ack}, 32'd0);
        check("midreset_wr_ret_ack", {31'd0, wr_ret_ack}, 32'd0);
        idle(8);
        check("postreset_rd_inflight", 32'(rd_inflight), 32'd0);
        rd(16'h0040, 16'h5A5A);
        idle(8);

        check("wr_pending_at_end", 32'(wr_q.size()), 32'd0);
        check("rd_pending_at_end", 32'(rd_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
